// File: rtl/rv64_pkg.sv
// rv64_pkg: shared RV64 decode types and encoding constants.
package rv64_pkg;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] F7_BASE     = 7'b0000000;
    localparam logic [6:0] F7_ALT      = 7'b0100000;
    localparam logic [6:0] F7_MULDIV   = 7'b0000001;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] imm;
        logic [63:0] imm64;
        logic        width_32;
    } decoded_inst_t;
endpackage

// File: rtl/rv64_inst_cracker.sv
// rv64_inst_cracker: combinational RV64 instruction word -> decoded fields + illegal flag.
// Ports: instr_i (raw 32-bit word), inst_o (decoded_inst_t), illegal_o (encoding not accepted).
// Config: RV64_DECODE_MEXT_EN makes funct7=0000001 on OP/OP-32 legal M-extension.
module rv64_inst_cracker
    import rv64_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]   instr_i,
    output decoded_inst_t inst_o,
    output logic          illegal_o
);
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic            is_i, is_shift, known, mext_ok, op_bad, opimm_bad, opimm32_bad;
    logic [XLEN-1:0] imm_x;

    assign opc      = instr_i[6:0];
    assign f3       = instr_i[14:12];
    assign f7       = instr_i[31:25];
    assign is_i     = opc inside {OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_JALR};
    assign is_shift = f3 == 3'b001 || f3 == 3'b101;
    assign known    = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                  OPC_STORE, OPC_OPIMM, OPC_OPIMM32, OPC_OP, OPC_OP32,
                                  OPC_MISCMEM, OPC_SYSTEM};
`ifdef RV64_DECODE_MEXT_EN
    // OP-32 has no word forms of MULH/MULHSU/MULHU
    assign mext_ok = f7 == F7_MULDIV && (opc == OPC_OP || !(f3 inside {3'b001, 3'b010, 3'b011}));
`else
    assign mext_ok = 1'b0;
`endif
    assign op_bad      = !mext_ok && ((f7 != F7_BASE && f7 != F7_ALT) ||
                                      (f7 == F7_ALT && !(f3 inside {3'b000, 3'b101})) ||
                                      (opc == OPC_OP32 && f3 inside {3'b010, 3'b011, 3'b100, 3'b110, 3'b111}));
    assign opimm_bad   = is_shift && !(instr_i[31:26] inside {6'b000000, 6'b010000});
    assign opimm32_bad = !(f3 inside {3'b000, 3'b001, 3'b101}) ||
                         (is_shift && !(instr_i[31:25] inside {F7_BASE, F7_ALT}));

    assign illegal_o = instr_i[1:0] != 2'b11 || !known ||
                       ((opc == OPC_OP || opc == OPC_OP32) && op_bad) ||
                       (opc == OPC_OPIMM && opimm_bad) ||
                       (opc == OPC_OPIMM32 && opimm32_bad) ||
                       (opc == OPC_JALR && f3 != 3'b000) ||
                       (opc == OPC_BRANCH && f3[2:1] == 2'b01) ||
                       (opc == OPC_LOAD && f3 == 3'b111) ||
                       (opc == OPC_STORE && f3[2]);

    always_comb begin
        imm_x = is_i ? {{(XLEN-12){instr_i[31]}}, instr_i[31:20]} :
                opc == OPC_STORE ? {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                opc == OPC_BRANCH ? {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                (opc == OPC_LUI || opc == OPC_AUIPC) ? {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0} :
                opc == OPC_JAL ? {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                '0;
    end

    always_comb begin
        inst_o.opcode   = opc;
        inst_o.rd       = instr_i[11:7];
        inst_o.rs1      = instr_i[19:15];
        inst_o.rs2      = instr_i[24:20];
        inst_o.funct3   = f3;
        inst_o.funct7   = f7;
        inst_o.imm      = is_i ? instr_i[31:20] : opc == OPC_STORE ? {instr_i[31:25], instr_i[11:7]} : 12'd0;
        inst_o.imm64    = imm_x;
        inst_o.width_32 = opc == OPC_OP32 || opc == OPC_OPIMM32;
    end
endmodule

// File: rtl/rv64_decode_stage.sv
// rv64_decode_stage: registered decode stage with 2-entry skid buffer between fetch and execute.
// Ports: clk, rst_n (async active-low), flush (drop all held entries);
//        fetch side in_valid/in_ready(registered)/in_pc/in_instr;
//        execute side out_valid/out_ready/out_pc/out_inst/out_illegal.
// Config: RV64_DECODE_MEXT_EN (see rv64_inst_cracker) enables M-extension decode.
module rv64_decode_stage
    import rv64_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output decoded_inst_t   out_inst,
    output logic            out_illegal
);
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            in_ready_q, in_x, out_x, dec_ill;
    decoded_inst_t   dec_inst, main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic            main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;

    rv64_inst_cracker #(.XLEN(XLEN)) u_cracker (
        .instr_i   (in_instr),
        .inst_o    (dec_inst),
        .illegal_o (dec_ill)
    );

    assign in_x = in_valid && in_ready_q;
    assign out_x = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        main_ill_d  = main_ill_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        skid_ill_d  = skid_ill_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (state_q == EMPTY || (state_q == ONE && in_x && out_x)) begin
            if (in_x) begin
                state_d     = ONE;
                main_pc_d   = in_pc;
                main_inst_d = dec_inst;
                main_ill_d  = dec_ill;
            end
        end else if (state_q == ONE) begin
            if (in_x) begin
                state_d     = FULL;
                skid_pc_d   = in_pc;
                skid_inst_d = dec_inst;
                skid_ill_d  = dec_ill;
            end else if (out_x) begin
                state_d = EMPTY;
            end
        end else if (out_x) begin
            // in_ready is low in FULL, so only the skid entry can advance
            state_d     = ONE;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            main_ill_d  = skid_ill_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_pc_q   <= '0;
            main_inst_q <= '0;
            main_ill_q  <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d != FULL;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            main_ill_q  <= main_ill_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_ill_q  <= skid_ill_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = state_q != EMPTY;
    assign out_pc      = main_pc_q;
    assign out_inst    = main_inst_q;
    assign out_illegal = main_ill_q;
endmodule

// File: tb/tb_rv64_decode_stage.sv
// tb_rv64_decode_stage: directed-vector self-checking bench for rv64_decode_stage.
module tb_rv64_decode_stage;
    import rv64_pkg::*;

    logic          clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0]   in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic          in_ready, out_valid, out_illegal;
    logic [63:0]   out_pc;
    decoded_inst_t out_inst;
    int            n_vec = 0, n_err = 0;
    logic [63:0]   got[$];
    logic [63:0]   pcs[4];
    int            idx;
    logic          acc;

    always #5 clk = ~clk;

    rv64_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_illegal (out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] pc, input logic [31:0] w);
        in_valid = 1'b1;
        in_pc = pc;
        in_instr = w;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        pcs = '{64'h0, 64'h4, 64'h8, 64'hC};
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_inst_zero", 64'(|out_inst), 64'd0);
        check("rst_illegal", 64'(out_illegal), 64'd0);
        #10 rst_n = 1'b1;
        step();

        load(64'h100, 32'hFFF00093);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_pc", out_pc, 64'h100);
        check("addi_opcode", 64'(out_inst.opcode), 64'h13);
        check("addi_rd", 64'(out_inst.rd), 64'd1);
        check("addi_rs1", 64'(out_inst.rs1), 64'd0);
        check("addi_imm", 64'(out_inst.imm), 64'hFFF);
        check("addi_imm64", out_inst.imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_w32", 64'(out_inst.width_32), 64'd0);
        check("addi_illegal", 64'(out_illegal), 64'd0);
        drain();
        check("addi_drained", 64'(out_valid), 64'd0);

        load(64'h104, 32'h4033529B);
        check("sraiw_w32", 64'(out_inst.width_32), 64'd1);
        check("sraiw_f3", 64'(out_inst.funct3), 64'd5);
        check("sraiw_imm_hi", 64'(out_inst.imm[11:5]), 64'h20);
        check("sraiw_rd", 64'(out_inst.rd), 64'd5);
        check("sraiw_rs1", 64'(out_inst.rs1), 64'd6);
        check("sraiw_illegal", 64'(out_illegal), 64'd0);
        drain();
        load(64'h108, 32'h4233529B);
        check("sraiw_b25_illegal", 64'(out_illegal), 64'd1);
        drain();

        load(64'h10C, 32'h022081B3);
        check("mul_f7", 64'(out_inst.funct7), 64'd1);
`ifdef RV64_DECODE_MEXT_EN
        check("mul_illegal", 64'(out_illegal), 64'd0);
`else
        check("mul_illegal", 64'(out_illegal), 64'd1);
`endif
        drain();

        load(64'h110, 32'h800002B7);
        check("lui_imm64", out_inst.imm64, 64'hFFFF_FFFF_8000_0000);
        check("lui_imm", 64'(out_inst.imm), 64'd0);
        check("lui_illegal", 64'(out_illegal), 64'd0);
        drain();
        load(64'h114, 32'hFE000EE3);
        check("beq_imm64", out_inst.imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_illegal", 64'(out_illegal), 64'd0);
        drain();
        load(64'h118, 32'h008000EF);
        check("jal_imm64", out_inst.imm64, 64'd8);
        check("jal_rd", 64'(out_inst.rd), 64'd1);
        drain();
        load(64'h11C, 32'hFE20BC23);
        check("sd_imm", 64'(out_inst.imm), 64'hFF8);
        check("sd_imm64", out_inst.imm64, 64'hFFFF_FFFF_FFFF_FFF8);
        check("sd_illegal", 64'(out_illegal), 64'd0);
        drain();
        load(64'h120, 32'h00000000);
        check("zero_illegal", 64'(out_illegal), 64'd1);
        check("zero_forwarded", 64'(out_valid), 64'd1);
        drain();

        // backpressure then release: strict FIFO order, no loss or duplication
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        for (int c = 0; c < 4; c++) begin
            in_pc = pcs[idx];
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        check("stream_accepted", 64'(idx), 64'd2);
        check("stream_full_ready", 64'(in_ready), 64'd0);
        check("stream_hold_pc", out_pc, 64'h0);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got.size() < 4; c++) begin
            in_valid = idx < 4;
            in_pc = pcs[idx < 4 ? idx : 3];
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_pc);
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stream_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stream_order%0d", i), i < got.size() ? got[i] : 64'hDEAD, pcs[i]);
        check("stream_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // flush while FULL with a word also offered
        load(64'h300, 32'h00100093);
        in_valid = 1'b1;
        in_pc = 64'h304;
        step();
        check("flush_pre_full", 64'(in_ready), 64'd0);
        in_pc = 64'h308;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        step();
        check("flush_no_ghost", 64'(out_valid), 64'd0);
        load(64'h400, 32'h00100093);
        check("post_flush_pc", out_pc, 64'h400);
        drain();

        // async reset between edges
        load(64'h500, 32'hFFF00093);
        check("arst_pre_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_pc", out_pc, 64'd0);
        check("arst_inst", 64'(|out_inst), 64'd0);
        check("arst_illegal", 64'(out_illegal), 64'd0);
        #2 rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rv64_decode_stage.md
Name: rv64_decode_stage

Overview:
- Registered decode pipeline stage for the RV64 core.
- Takes raw 32-bit instruction words plus PC from fetch over a valid/ready handshake.
- Cracks each word into the shared decoded_inst_t structure that the execute-stage ALU consumes.
- Presents the result to execute over a second valid/ready handshake. A 2-entry skid buffer keeps in_ready fully registered, so there is no combinational path from out_ready to in_ready.

Parameters:
- XLEN, 64, datapath/PC width; only 64 is supported.
- PC_W, 64, width of the PC carried alongside each instruction.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill all held entries (branch redirect/trap).
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  PC_W  PC of the word.
- in_instr  in  32  raw instruction.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute accepts.
- out_pc  out  PC_W  PC of the presented entry.
- out_inst  out  decoded_inst_t  opcode, rd, rs1, rs2, funct3, funct7, imm(12), imm64, width_32.
- out_illegal  out  1  presented entry is an illegal encoding.

Behaviour:
- Reset (async, rst_n=0):
  - State is EMPTY.
  - out_valid=0, in_ready=1.
  - out_pc, out_inst and out_illegal are all zero.
  - The skid register is cleared.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready; output transfer occurs when out_valid&&out_ready.
  - Payload is held stable while out_valid=1 and out_ready=0.
- Latency: an accepted word appears on out_* on the next edge when the stage was EMPTY.
- FSM states:
  - EMPTY: main register empty.
  - ONE: main register valid.
  - FULL: main and skid registers both valid.
- FSM transitions:
  - EMPTY + in xfer → ONE.
  - ONE + in xfer + no out xfer → FULL; the word goes to skid and in_ready←0.
  - ONE + out xfer + no in xfer → EMPTY.
  - ONE + both xfers → ONE, with main loaded from the input.
  - FULL + out xfer → ONE: skid moves to main and in_ready←1. in_ready is 0 in FULL, so no input is taken that cycle.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Flush:
  - At the next edge, state→EMPTY, out_valid=0 and in_ready=1.
  - An input presented in the flush cycle is dropped.
  - An out xfer in the flush cycle still counts for the consumer.
  - Flush overrides all simultaneous events.
- Decoding is pure combinational logic applied before the input register. Decoded fields, not raw words, are stored.
- Field extraction: rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12], funct7=[31:25].
- imm (12 bits) = I-type [31:20] for OP-IMM, OP-IMM-32, LOAD, JALR; S-type immediate for STORE; 0 otherwise.
- imm64 = sign-extended immediate for all formats:
  - I, S.
  - B: bit0=0.
  - U: [31:12]<<12, sign-extended from bit 31.
  - J: bit0=0.
- width_32=1 only for opcodes 0111011 (OP-32) and 0011011 (OP-IMM-32).
- Illegal encodings (entry still forwarded with out_illegal=1, never dropped):
  - instr[1:0]!=2'b11.
  - Opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP-IMM-32, OP, OP-32, MISC-MEM, SYSTEM}.
  - OP/OP-32 with funct7 ∉ {0000000, 0100000}, or with 0100000 and funct3 ∉ {000, 101}.
  - OP-32 with funct3 ∈ {010, 011, 100, 110, 111}.
  - OP-IMM shifts with imm[11:6] ∉ {000000, 010000}.
  - OP-IMM-32 shifts with imm[11:5] ∉ {0000000, 0100000}.
  - OP-IMM-32 with funct3 ∉ {000, 001, 101}.
  - JALR with funct3≠000.
  - BRANCH with funct3 ∈ {010, 011}.
  - LOAD with funct3=111; STORE with funct3[2]=1.

Optional Feature:
- Macro: RV64_DECODE_MEXT_EN.
- Defined: funct7=0000001 on OP (all funct3) and on OP-32 (funct3 ∈ {000, 100, 101, 110, 111}) decodes as legal M-extension.
- Undefined: any funct7=0000001 on OP/OP-32 sets out_illegal=1. All other behaviour is identical.

Decomposition:
- Shared package rv64_pkg holds:
  - decoded_inst_t.
  - Opcode localparams OPC_OP, OPC_OP32, OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISCMEM.
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
- One sub-module, rv64_inst_cracker: purely combinational instr → {decoded_inst_t, illegal}. The top level holds the skid FSM and registers.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093) → 1 cycle later out_valid=1; opcode=0010011, rd=1, rs1=0, imm=0xFFF, imm64=0xFFFF_FFFF_FFFF_FFFF, width_32=0, out_illegal=0.
- SRAIW x5,x6,3 (0x4033529B) → width_32=1, funct3=101, imm[11:5]=0100000, legal. Same word with bit25 set (0x4233529B) → out_illegal=1.
- MUL x3,x1,x2 (0x022081B3) → with RV64_DECODE_MEXT_EN, funct7=0000001 and legal; without it, out_illegal=1.
- Hold out_ready=0, stream 4 words with PCs 0x0/0x4/0x8/0xC → the first two are accepted, then in_ready=0. Release out_ready → outputs in PC order 0x0, 0x4, 0x8, 0xC with no loss or duplication.
- FULL state, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle word never appears.
- Deassert rst_n mid-stream, asynchronously between edges → out_valid drops immediately, in_ready=1, and the payload is zeroed.
